// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: the decode/writeback-facing bus of reg_file_mp.
//   Parameters : DATA_WIDTH, ADDR_WIDTH (must match the attached reg_file_mp).
//   Write port : IN, INADDRESS, WRITE
//   Read ports : OUT1ADDRESS/OUT1/OUT1BUSY, OUT2ADDRESS/OUT2/OUT2BUSY
//   Scoreboard : RESERVE, RESADDRESS
//   Sweep      : CLEAR, CLEARBUSY
//   Optional (REG_FILE_PARITY_EN): PERR_INJECT, OUT1PERR, OUT2PERR
// Modports: master = the datapath driving the file, slave = the register file.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] IN;
    logic [ADDR_WIDTH-1:0] INADDRESS;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic [DATA_WIDTH-1:0] OUT1;
    logic [DATA_WIDTH-1:0] OUT2;
    logic                  RESERVE;
    logic [ADDR_WIDTH-1:0] RESADDRESS;
    logic                  OUT1BUSY;
    logic                  OUT2BUSY;
    logic                  CLEAR;
    logic                  CLEARBUSY;
`ifdef REG_FILE_PARITY_EN
    logic                  PERR_INJECT;
    logic                  OUT1PERR;
    logic                  OUT2PERR;
`endif

    modport master (
`ifdef REG_FILE_PARITY_EN
        output PERR_INJECT, input OUT1PERR, OUT2PERR,
`endif
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        output RESERVE, RESADDRESS, CLEAR,
        input  OUT1, OUT2, OUT1BUSY, OUT2BUSY, CLEARBUSY
    );

    modport slave (
`ifdef REG_FILE_PARITY_EN
        input PERR_INJECT, output OUT1PERR, OUT2PERR,
`endif
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        input  RESERVE, RESADDRESS, CLEAR,
        output OUT1, OUT2, OUT1BUSY, OUT2BUSY, CLEARBUSY
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file, one write port, two combinational
// read ports with write-to-read bypass, per-register pending scoreboard and a
// DEPTH-cycle CLEAR sweep.
//   CLK     : clock, all state updates on the rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : reg_file_mp_if.slave (write/read/reserve/clear signals)
// Parameters: DATA_WIDTH, ADDR_WIDTH (DEPTH = 2**ADDR_WIDTH), ZERO_REG
// (register 0 hardwired to zero, never busy).
// Optional macro REG_FILE_PARITY_EN: per-entry even parity bit, PERR_INJECT
// input and OUT1PERR/OUT2PERR outputs on the bus.
module reg_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit ZERO_REG   = 1'b0
) (
    input logic         CLK,
    input logic         RESET_N,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic {IDLE, SWEEP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;
`ifdef REG_FILE_PARITY_EN
        logic                  perr;
`endif
    } rd_t;

    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     regs_q;
    logic [DEPTH-1:0]                     pending_q;
`ifdef REG_FILE_PARITY_EN
    logic [DEPTH-1:0]                     par_q;
`endif

    logic                  idle;
    logic                  wr_vis;
    logic                  wr_en;
    logic                  rs_en;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] din;
    rd_t                   rp1, rp2;

    assign idle = (state_q == IDLE);
    assign wa   = bus.INADDRESS;
    assign din  = bus.IN;
    // Writes are visible (bypass) only when the file would accept them; the
    // RESET_N term keeps the outputs at zero while reset is held.
    assign wr_vis = bus.WRITE & idle & RESET_N;
    assign wr_en  = wr_vis & ~(ZERO_REG && wa == '0);
    assign rs_en  = bus.RESERVE & idle & ~(ZERO_REG && bus.RESADDRESS == '0);

    function automatic rd_t read_port(input logic [ADDR_WIDTH-1:0] a);
        rd_t  r;
        logic hit, zhit;
        zhit   = ZERO_REG && (a == '0);
        hit    = wr_vis && (wa == a) && !zhit;
        r.data = zhit ? '0 : (hit ? din : regs_q[a]);
        r.busy = pending_q[a] & ~hit & ~zhit;
`ifdef REG_FILE_PARITY_EN
        r.perr = (hit || zhit) ? 1'b0 : (par_q[a] != ^regs_q[a]);
`endif
        return r;
    endfunction

    always_comb begin
        rp1 = read_port(bus.OUT1ADDRESS);
        rp2 = read_port(bus.OUT2ADDRESS);
    end

    assign bus.OUT1      = rp1.data;
    assign bus.OUT2      = rp2.data;
    assign bus.OUT1BUSY  = rp1.busy;
    assign bus.OUT2BUSY  = rp2.busy;
    assign bus.CLEARBUSY = (state_q == SWEEP);
`ifdef REG_FILE_PARITY_EN
    assign bus.OUT1PERR  = rp1.perr;
    assign bus.OUT2PERR  = rp2.perr;
`endif

    // Sweep FSM: CLEAR in IDLE starts a DEPTH-cycle walk of cnt over all
    // entries; the counter wraps to 0 on the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.CLEAR) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH-1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            regs_q    <= '0;
            pending_q <= '0;
`ifdef REG_FILE_PARITY_EN
            par_q     <= '0;
`endif
        end else if (!idle) begin
            regs_q[cnt_q]    <= '0;
            pending_q[cnt_q] <= 1'b0;
`ifdef REG_FILE_PARITY_EN
            par_q[cnt_q]     <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                regs_q[wa]    <= din;
                pending_q[wa] <= 1'b0;
`ifdef REG_FILE_PARITY_EN
                par_q[wa]     <= (^din) ^ bus.PERR_INJECT;
`endif
            end
            // Ordered after the write so a same-address reserve leaves the
            // entry pending: a new producer has been issued.
            if (rs_en) pending_q[bus.RESADDRESS] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: table-driven bench for reg_file_mp. Two instances share the
// same stimulus: dut (ZERO_REG = 0) and dutz (ZERO_REG = 1); each vector says
// which one it checks. Expected values are hand-derived and queued when the
// vector is driven, then popped and compared on the following falling edge.
module tb_reg_file_mp;
    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    reg_file_mp_if bus ();
    reg_file_mp_if zbus ();

    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus));
    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) dutz (
        .CLK(CLK), .RESET_N(RESET_N), .bus(zbus));

    typedef struct {
        logic       wr;
        logic [2:0] ia;
        logic [7:0] din;
        logic       rs;
        logic [2:0] ra;
        logic       clr;
        logic       pinj;
        logic [2:0] a1, a2;
        logic [7:0] e1, e2;
        logic       eb1, eb2, ecb;
        logic       ep1, ep2;
        logic       z;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[15];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(input logic wr, input logic [2:0] ia, input logic [7:0] din,
                                input logic rs, input logic [2:0] ra,
                                input logic [2:0] a1, input logic [2:0] a2,
                                input logic [7:0] e1, input logic [7:0] e2,
                                input logic eb1, input logic eb2);
        vec_t v;
        v.wr = wr; v.ia = ia; v.din = din; v.rs = rs; v.ra = ra;
        v.clr = 1'b0; v.pinj = 1'b0; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ecb = 1'b0;
        v.ep1 = 1'b0; v.ep2 = 1'b0; v.z = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.WRITE = v.wr;   bus.INADDRESS = v.ia; bus.IN = v.din;
        bus.RESERVE = v.rs; bus.RESADDRESS = v.ra; bus.CLEAR = v.clr;
        bus.OUT1ADDRESS = v.a1; bus.OUT2ADDRESS = v.a2;
        zbus.WRITE = v.wr;   zbus.INADDRESS = v.ia; zbus.IN = v.din;
        zbus.RESERVE = v.rs; zbus.RESADDRESS = v.ra; zbus.CLEAR = v.clr;
        zbus.OUT1ADDRESS = v.a1; zbus.OUT2ADDRESS = v.a2;
`ifdef REG_FILE_PARITY_EN
        bus.PERR_INJECT = v.pinj;
        zbus.PERR_INJECT = v.pinj;
`endif
    endtask

    // Drive one vector, compare outputs on the falling edge, move past the
    // next rising edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        logic [7:0] o1, o2;
        logic b1, b2, cb;
        drive(v);
        exp_q.push_back(v);
        @(negedge CLK);
        e = exp_q.pop_front();
        if (e.z) begin
            o1 = zbus.OUT1; o2 = zbus.OUT2; b1 = zbus.OUT1BUSY; b2 = zbus.OUT2BUSY; cb = zbus.CLEARBUSY;
        end else begin
            o1 = bus.OUT1; o2 = bus.OUT2; b1 = bus.OUT1BUSY; b2 = bus.OUT2BUSY; cb = bus.CLEARBUSY;
        end
        chk({tag, " out1"}, o1, e.e1);
        chk({tag, " out2"}, o2, e.e2);
        chk({tag, " out1busy"}, 8'(b1), 8'(e.eb1));
        chk({tag, " out2busy"}, 8'(b2), 8'(e.eb2));
        chk({tag, " clearbusy"}, 8'(cb), 8'(e.ecb));
`ifdef REG_FILE_PARITY_EN
        chk({tag, " out1perr"}, 8'(e.z ? zbus.OUT1PERR : bus.OUT1PERR), 8'(e.ep1));
        chk({tag, " out2perr"}, 8'(e.z ? zbus.OUT2PERR : bus.OUT2PERR), 8'(e.ep2));
`endif
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //           wr ia  din   rs ra  a1 a2  e1     e2     b1 b2
        tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0, 7, 8'h00, 8'h00, 0, 0);
        tbl[1]  = mk(1, 5, 8'hA7, 0, 0, 5, 5, 8'hA7, 8'hA7, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0, 0, 5, 0, 8'hA7, 8'h00, 0, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1, 3, 3, 3, 8'h00, 8'h00, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 0, 0, 5, 3, 8'hA7, 8'h00, 0, 1);
        tbl[5]  = mk(1, 3, 8'h11, 0, 0, 3, 3, 8'h11, 8'h11, 0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0, 0, 3, 5, 8'h11, 8'hA7, 0, 0);
        tbl[7]  = mk(1, 3, 8'h22, 1, 3, 3, 3, 8'h22, 8'h22, 0, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 0, 3, 3, 8'h22, 8'h22, 1, 1);
        tbl[9]  = mk(1, 6, 8'h5A, 0, 0, 6, 3, 8'h5A, 8'h22, 0, 1);
        tbl[10] = mk(1, 3, 8'h33, 0, 0, 3, 6, 8'h33, 8'h5A, 0, 0);
        tbl[11] = mk(0, 0, 8'h00, 0, 0, 3, 6, 8'h33, 8'h5A, 0, 0);
        tbl[12] = mk(1, 7, 8'hFF, 0, 0, 7, 1, 8'hFF, 8'h00, 0, 0);
        tbl[13] = mk(1, 2, 8'h44, 1, 1, 1, 2, 8'h00, 8'h44, 0, 0);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 1, 2, 8'h00, 8'h44, 1, 0);

        // Reset held: everything reads zero, including an attempted bypass.
        RESET_N = 1'b0;
        drive(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        @(posedge CLK); #1;
        for (int k = 0; k < 8; k += 2)
            step(mk(0, 0, 8'h00, 0, 0, 3'(k), 3'(k+1), 8'h00, 8'h00, 0, 0), $sformatf("rst%0d", k));
        step(mk(1, 4, 8'hAB, 1, 4, 4, 4, 8'h00, 8'h00, 0, 0), "rst_wr");
        // Release mid-cycle with no write pending; nothing may appear.
        drive(mk(0, 4, 8'hAB, 0, 4, 4, 4, 8'h00, 8'h00, 0, 0));
        #2 RESET_N = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 8; k += 2)
            step(mk(0, 0, 8'h00, 0, 0, 3'(k), 3'(k+1), 8'h00, 8'h00, 0, 0), $sformatf("post%0d", k));

        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Load 0x10..0x17, reserve reg 5 alongside the last write.
        for (int k = 0; k < 8; k++)
            step(mk(1, 3'(k), 8'(8'h10 + k), k == 7, 5, 3'(k), 3'(k),
                    8'(8'h10 + k), 8'(8'h10 + k), 0, 0), $sformatf("load%0d", k));
        // CLEAR together with a write: write lands, sweep follows.
        v = mk(1, 2, 8'h99, 0, 0, 2, 5, 8'h99, 8'h15, 0, 1);
        v.clr = 1'b1;
        step(v, "clr");
        for (int c = 0; c < 8; c++) begin
            logic far;
            far = (c == 0) || (c == 3);
            v = mk(0, 0, 8'h00, 0, 0, 3'(c), far ? 3'd7 : 3'(c-1),
                   (c == 2) ? 8'h99 : 8'(8'h10 + c), far ? 8'h17 : 8'h00, c == 5, 0);
            v.ecb = 1'b1;
            if (c == 3) begin
                v.wr = 1'b1; v.ia = 7; v.din = 8'hEE; v.rs = 1'b1; v.ra = 6; v.clr = 1'b1;
            end
            step(v, $sformatf("sweep%0d", c));
        end
        for (int k = 0; k < 8; k++)
            step(mk(0, 0, 8'h00, 0, 0, 3'(k), 3'(7-k), 8'h00, 8'h00, 0, 0), $sformatf("swept%0d", k));

        // ZERO_REG instance: register 0 ignores writes/reserves, never bypasses.
        v = mk(1, 0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0); v.z = 1'b1; step(v, "z_wr0");
        v = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0); v.z = 1'b1; step(v, "z_rd0");
        v = mk(1, 1, 8'h55, 0, 0, 1, 0, 8'h55, 8'h00, 0, 0); v.z = 1'b1; step(v, "z_wr1");
        v = mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h55, 8'h55, 0, 0); v.z = 1'b1; step(v, "z_rd1");
        // Same traffic on the normal instance keeps register 0.
        step(mk(1, 0, 8'hFF, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0), "nz_wr0");
        step(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 1), "nz_rd0");

`ifdef REG_FILE_PARITY_EN
        v = mk(1, 2, 8'h3C, 0, 0, 2, 3, 8'h3C, 8'h00, 0, 0); v.pinj = 1'b1; step(v, "p_inj");
        v = mk(0, 0, 8'h00, 0, 0, 2, 3, 8'h3C, 8'h00, 0, 0); v.ep1 = 1'b1; step(v, "p_err");
        step(mk(1, 2, 8'h3C, 0, 0, 3, 2, 8'h00, 8'h3C, 0, 0), "p_fix");
        step(mk(0, 0, 8'h00, 0, 0, 2, 3, 8'h3C, 8'h00, 0, 0), "p_ok");
`endif

        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
